ram_arbiter: RTL and testbench

- Shares the single 8-byte scratch RAM (one read port, one write port, 1-cycle registered read) between NUM_REQ requesters, e.g. the host command decoder and the flight-control loop.
- Serialises requests with a round-robin grant, drives the RAM strobes, and returns read data with a per-requester acknowledge.
- Sits directly between the requesters and the RAM instance.

---
 rtl/ram_arb_pkg.sv | 26 ++
 rtl/ram_arbiter_rr_picker.sv | 56 +++++
 rtl/ram_arbiter.sv | 145 ++++++++++++++
 tb/tb_ram_arbiter.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/ram_arb_pkg.sv
// ram_arb_pkg
// Shared definitions for the scratch-RAM arbiter.
//   - FSM state encoding (IDLE, ACCESS, RESP)
//   - default RAM geometry: RAM_DEPTH, RAM_ADDR_W, RAM_DATA_W
//   - addr_in_range(): full-width address bound check (no modulo wrap)
// Optional build macro used by this slice: RAM_ARB_FIXED_PRIORITY_EN
// (consumed in rr_picker).
package ram_arb_pkg;

    localparam int RAM_DEPTH  = 8;
    localparam int RAM_ADDR_W = 8;
    localparam int RAM_DATA_W = 8;

    typedef logic [1:0] state_t;
    localparam state_t ST_IDLE   = 2'd0;
    localparam state_t ST_ACCESS = 2'd1;
    localparam state_t ST_RESP   = 2'd2;

    // Caller zero-extends the address to 32 bits, so upper address bits
    // take part in the compare rather than being dropped.
    function automatic logic addr_in_range(input logic [31:0] addr,
                                           input logic [31:0] depth);
        return (addr < depth);
    endfunction

endpackage

// File: rtl/ram_arbiter_rr_picker.sv
// rr_picker
// Combinational arbiter pick for ram_arbiter.
// Ports:
//   req        in  NUM_REQ  request levels
//   last_grant in  IDX_W    index of the previous winner
//   grant      out NUM_REQ  one-hot winner (0 when no request)
//   valid      out 1        at least one request present
// Build macro RAM_ARB_FIXED_PRIORITY_EN: when defined, lowest index always
// wins and last_grant is ignored; otherwise round-robin starting after
// last_grant.
module rr_picker #(
    parameter int NUM_REQ = 2,
    parameter int IDX_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   last_grant,
    output logic [NUM_REQ-1:0] grant,
    output logic               valid
);

    assign valid = |req;

`ifdef RAM_ARB_FIXED_PRIORITY_EN
    logic unused_last_grant;
    assign unused_last_grant = ^last_grant;

    always_comb begin
        grant = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (req[i]) begin
                grant    = '0;
                grant[i] = 1'b1;
            end
        end
    end
`else
    logic [IDX_W-1:0] idx;
    logic             found;

    // Scan starts one past the previous winner and wraps, so the previous
    // winner is considered last.
    always_comb begin
        grant = '0;
        found = 1'b0;
        idx   = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            idx = IDX_W'((int'(last_grant) + k) % NUM_REQ);
            if (!found && req[idx]) begin
                grant[idx] = 1'b1;
                found      = 1'b1;
            end
        end
    end
`endif

endmodule

// File: rtl/ram_arbiter.sv
// ram_arbiter
// Shares one scratch RAM (1 read port, 1 write port, registered read)
// between NUM_REQ requesters. Each transaction runs IDLE -> ACCESS -> RESP.
// Ports:
//   clk_system, reset_n            clock, async active-low reset
//   req/req_wr/req_addr/req_wdata  per-requester request (packed slices)
//   ack, err, rdata                one-hot completion pulse, range error, read data
//   ram_rd/ram_rd_addr             RAM read strobe/address
//   ram_wr/ram_wr_addr/ram_wr_data RAM write strobe/address/data
//   ram_rd_data                    RAM read data (valid the cycle after ram_rd)
// Build macro RAM_ARB_FIXED_PRIORITY_EN selects fixed priority arbitration.
module ram_arbiter
    import ram_arb_pkg::*;
#(
    parameter int NUM_REQ = 2,
    parameter int ADDR_W  = RAM_ADDR_W,
    parameter int DATA_W  = RAM_DATA_W,
    parameter int DEPTH   = RAM_DEPTH
) (
    input  logic                      clk_system,
    input  logic                      reset_n,
    input  logic [NUM_REQ-1:0]        req,
    input  logic [NUM_REQ-1:0]        req_wr,
    input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
    input  logic [NUM_REQ*DATA_W-1:0] req_wdata,
    output logic [NUM_REQ-1:0]        ack,
    output logic                      err,
    output logic [DATA_W-1:0]         rdata,
    output logic [ADDR_W-1:0]         ram_rd_addr,
    output logic                      ram_rd,
    output logic [ADDR_W-1:0]         ram_wr_addr,
    output logic                      ram_wr,
    output logic [DATA_W-1:0]         ram_wr_data,
    input  logic [DATA_W-1:0]         ram_rd_data
);

    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    state_t              state_q, state_d;
    logic [NUM_REQ-1:0]  grant_q, grant_d;
    logic [IDX_W-1:0]    last_grant_q, last_grant_d;
    logic                wr_q, wr_d;
    logic                in_range_q, in_range_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;

    logic [NUM_REQ-1:0]  pick_grant;
    logic                pick_valid;
    logic [IDX_W-1:0]    pick_idx;
    logic                sel_wr;
    logic [ADDR_W-1:0]   sel_addr;
    logic [DATA_W-1:0]   sel_wdata;
    logic                in_access;
    logic                in_resp;

    rr_picker #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_picker (
        .req        (req),
        .last_grant (last_grant_q),
        .grant      (pick_grant),
        .valid      (pick_valid)
    );

    // One-hot grant to index plus request-field mux.
    always_comb begin
        pick_idx  = '0;
        sel_wr    = 1'b0;
        sel_addr  = '0;
        sel_wdata = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (pick_grant[i]) begin
                pick_idx  = IDX_W'(i);
                sel_wr    = req_wr[i];
                sel_addr  = req_addr[i*ADDR_W +: ADDR_W];
                sel_wdata = req_wdata[i*DATA_W +: DATA_W];
            end
        end
    end

    always_comb begin
        state_d      = state_q;
        grant_d      = grant_q;
        last_grant_d = last_grant_q;
        wr_d         = wr_q;
        in_range_d   = in_range_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        case (state_q)
            ST_IDLE: begin
                if (pick_valid) begin
                    grant_d      = pick_grant;
                    last_grant_d = pick_idx;
                    wr_d         = sel_wr;
                    addr_d       = sel_addr;
                    wdata_d      = sel_wdata;
                    in_range_d   = addr_in_range(32'(sel_addr), 32'(DEPTH));
                    state_d      = ST_ACCESS;
                end
            end
            ST_ACCESS: state_d = ST_RESP;
            ST_RESP:   state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
    end

    // Control state: async reset so a mid-transaction reset kills all
    // strobes and ack immediately.
    always_ff @(posedge clk_system or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= ST_IDLE;
            grant_q      <= '0;
            last_grant_q <= IDX_W'(NUM_REQ - 1);
            wr_q         <= 1'b0;
            in_range_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            grant_q      <= grant_d;
            last_grant_q <= last_grant_d;
            wr_q         <= wr_d;
            in_range_q   <= in_range_d;
        end
    end

    // Captured address/data: every consumer is gated by state, so no reset.
    always_ff @(posedge clk_system) begin
        addr_q  <= addr_d;
        wdata_q <= wdata_d;
    end

    // Outputs decode straight from registered state.
    assign in_access   = (state_q == ST_ACCESS);
    assign in_resp     = (state_q == ST_RESP);
    assign ram_wr      = in_access & wr_q & in_range_q;
    assign ram_rd      = in_access & ~wr_q & in_range_q;
    assign ram_wr_addr = ram_wr ? addr_q : '0;
    assign ram_wr_data = ram_wr ? wdata_q : '0;
    assign ram_rd_addr = ram_rd ? addr_q : '0;
    assign ack         = in_resp ? grant_q : '0;
    assign err         = in_resp & ~in_range_q;
    // RAM registered the read on the edge leaving ACCESS.
    assign rdata       = (in_resp & ~wr_q & in_range_q) ? ram_rd_data : '0;

endmodule

// File: tb/tb_ram_arbiter.sv
module tb_ram_arbiter;

    logic        clk_system = 1'b0;
    logic        reset_n;
    logic [1:0]  req;
    logic [1:0]  req_wr;
    logic [15:0] req_addr;
    logic [15:0] req_wdata;
    logic [1:0]  ack;
    logic        err;
    logic [7:0]  rdata;
    logic [7:0]  ram_rd_addr;
    logic        ram_rd;
    logic [7:0]  ram_wr_addr;
    logic        ram_wr;
    logic [7:0]  ram_wr_data;
    logic [7:0]  ram_rd_data;

    int checks   = 0;
    int failures = 0;

    logic [7:0] mem [0:7];
    logic       both_strobes_seen = 1'b0;
    logic       oor_write_seen    = 1'b0;

    always #5 clk_system = ~clk_system;

    ram_arbiter #(
        .NUM_REQ (2),
        .ADDR_W  (8),
        .DATA_W  (8),
        .DEPTH   (8)
    ) dut (
        .clk_system  (clk_system),
        .reset_n     (reset_n),
        .req         (req),
        .req_wr      (req_wr),
        .req_addr    (req_addr),
        .req_wdata   (req_wdata),
        .ack         (ack),
        .err         (err),
        .rdata       (rdata),
        .ram_rd_addr (ram_rd_addr),
        .ram_rd      (ram_rd),
        .ram_wr_addr (ram_wr_addr),
        .ram_wr      (ram_wr),
        .ram_wr_data (ram_wr_data),
        .ram_rd_data (ram_rd_data)
    );

    // Behavioural scratch RAM with registered read.
    always @(posedge clk_system) begin
        if (ram_wr && ram_wr_addr < 8'd8) mem[ram_wr_addr[2:0]] <= ram_wr_data;
        if (ram_rd) ram_rd_data <= mem[ram_rd_addr[2:0]];
    end

    always @(negedge clk_system) begin
        if (ram_rd && ram_wr) both_strobes_seen = 1'b1;
        if (ram_wr && ram_wr_addr >= 8'd8) oor_write_seen = 1'b1;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_system);
        #1;
    endtask

    task automatic chk_quiet(input string tag);
        chk({tag, " quiet"}, {13'd0, ram_rd, ram_wr, err, ack, rdata, ram_wr_data},
            32'd0);
        chk({tag, " addrs"}, {16'd0, ram_rd_addr, ram_wr_addr}, 32'd0);
    endtask

    // One transaction from requester r, starting in IDLE; returns in the
    // cycle after ack with req dropped.
    task automatic txn(input int r, input logic wr, input logic [7:0] addr,
                       input logic [7:0] wd, input logic [7:0] exp_rd,
                       input logic exp_err, input string tag);
        req   = '0;
        req_wr = '0;
        req[r]    = 1'b1;
        req_wr[r] = wr;
        req_addr[r*8 +: 8]  = addr;
        req_wdata[r*8 +: 8] = wd;
        tick();
        if (exp_err) begin
            chk({tag, " no strobe"}, {30'd0, ram_rd, ram_wr}, 32'd0);
        end else if (wr) begin
            chk({tag, " wr strobe"}, {14'd0, ram_rd, ram_wr, ram_wr_addr, ram_wr_data},
                {14'd0, 1'b0, 1'b1, addr, wd});
        end else begin
            chk({tag, " rd strobe"}, {22'd0, ram_rd, ram_wr, ram_rd_addr},
                {22'd0, 1'b1, 1'b0, addr});
        end
        chk({tag, " early ack"}, 32'(ack), 32'd0);
        tick();
        chk({tag, " ack"}, 32'(ack), 32'd1 << r);
        chk({tag, " err"}, 32'(err), 32'(exp_err));
        chk({tag, " rdata"}, 32'(rdata), 32'(exp_rd));
        tick();
        chk({tag, " ack gone"}, 32'(ack), 32'd0);
        req = '0;
    endtask

    initial begin
        logic       idle_any;
        logic [1:0] exp_ack;
        logic [7:0] exp_dat;

        reset_n   = 1'b0;
        req       = '0;
        req_wr    = '0;
        req_addr  = '0;
        req_wdata = '0;
        for (int i = 0; i < 8; i++) mem[i] = 8'h00;
        #1;
        chk_quiet("reset");
        tick();
        tick();
        reset_n = 1'b1;
        tick();
        chk_quiet("post reset");

        // Idle: nothing moves for 20 cycles.
        idle_any = 1'b0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (ram_rd || ram_wr || err || ack != 2'b00) idle_any = 1'b1;
        end
        chk("idle activity", 32'(idle_any), 32'd0);
        chk_quiet("idle end");

        // Single write then read.
        txn(0, 1'b1, 8'd3, 8'hA5, 8'h00, 1'b0, "wr3");
        txn(0, 1'b0, 8'd3, 8'h00, 8'hA5, 1'b0, "rd3");

        // Back-to-back writes then reads.
        for (int i = 0; i < 8; i++)
            txn(0, 1'b1, 8'(i), 8'(8'h10 + i), 8'h00, 1'b0, $sformatf("bwr%0d", i));
        for (int i = 0; i < 8; i++)
            txn(0, 1'b0, 8'(i), 8'h00, 8'(8'h10 + i), 1'b0, $sformatf("brd%0d", i));

        // Out-of-range write, then the whole RAM must be unchanged.
        txn(1, 1'b1, 8'd8, 8'hFF, 8'h00, 1'b1, "oor8");
        txn(1, 1'b0, 8'hF0, 8'h00, 8'h00, 1'b1, "oorF0");
        for (int i = 0; i < 8; i++)
            txn(1, 1'b0, 8'(i), 8'h00, 8'(8'h10 + i), 1'b0, $sformatf("chk%0d", i));
        chk("oor write strobe", 32'(oor_write_seen), 32'd0);

        // Contention: both requesters hold reads of addr 1 (0x11) and 2 (0x22).
        txn(1, 1'b1, 8'd2, 8'h22, 8'h00, 1'b0, "pre2");
        req       = 2'b11;
        req_wr    = 2'b00;
        req_addr  = {8'd2, 8'd1};
        for (int n = 0; n < 4; n++) begin
`ifdef RAM_ARB_FIXED_PRIORITY_EN
            exp_ack = 2'b01;
`else
            exp_ack = (n % 2 == 0) ? 2'b01 : 2'b10;
`endif
            exp_dat = exp_ack[0] ? 8'h11 : 8'h22;
            tick();
            chk($sformatf("cont%0d rd addr", n), 32'(ram_rd_addr),
                exp_ack[0] ? 32'd1 : 32'd2);
            tick();
            chk($sformatf("cont%0d ack", n), 32'(ack), 32'(exp_ack));
            chk($sformatf("cont%0d rdata", n), 32'(rdata), 32'(exp_dat));
            tick();
        end
        req = '0;
        tick();
        chk("strobes exclusive", 32'(both_strobes_seen), 32'd0);

        // Reset during ACCESS of a write.
        req       = 2'b10;
        req_wr    = 2'b10;
        req_addr  = {8'd5, 8'd0};
        req_wdata = {8'h55, 8'h00};
        tick();
        chk("rst pre wr", 32'(ram_wr), 32'd1);
        reset_n = 1'b0;
        #1;
        chk_quiet("async reset");
        req = '0;
        tick();
        chk_quiet("in reset");
        tick();
        chk("rst no ack", 32'(ack), 32'd0);
        reset_n = 1'b1;
        req       = 2'b11;
        req_wr    = 2'b00;
        req_addr  = {8'd6, 8'd4};
        tick();
        tick();
        chk("rst first grant", 32'(ack), 32'd1);
        chk("rst first rdata", 32'(rdata), 32'h14);
        tick();
        req = '0;
        tick();
        tick();
        tick();
        txn(0, 1'b0, 8'd5, 8'h00, 8'h15, 1'b0, "rst abandoned");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
